// File: rtl/alu_pi_ctl.sv
// rtl/alu_pi_ctl.sv - PI register block sequencing one ALU operation with watchdog and abort
module alu_pi_ctl #(
  parameter int OP_BYTES = 4,
  parameter int ADDR_W   = 5,
  parameter int TMO_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pi_blk_sel,
  input  logic [ADDR_W-1:0]       pi_addr,
  input  logic                    pi_wr_en,
  input  logic                    pi_rd_en,
  input  logic [7:0]              pi_wr_data,
  output logic [7:0]              pi_rd_data,
  input  logic                    interrupt_ack,
  output logic                    interrupt,
  output logic                    alu_go_r,
  output logic                    alu_abort_r,
  output logic                    alu_en_r,
  output logic [3:0]              alu_func_r,
  output logic [8*OP_BYTES-1:0]   alu_op_a_r,
  output logic [8*OP_BYTES-1:0]   alu_op_b_r,
  input  logic                    alu_op_done,
  input  logic [8*OP_BYTES-1:0]   q_in,
  input  logic [8*OP_BYTES-1:0]   r_in
);
  localparam int OP_W = 8 * OP_BYTES;
  // Watchdog counter only needs to hold TMO_CYC; keep at least one bit when disabled.
  localparam int WD_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic              int_en_q, int_en_d;
  logic [3:0]        func_q, func_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              go_q, go_d, abort_q, abort_d;
  logic              done_q, done_d, tmo_q, tmo_d, err_q, err_d;
  logic              irq_q, irq_d;

  logic              wr_acc, wr_ctrl, wr_stat, go_req, abort_req, busy;
  logic              set_done, set_tmo, set_err;

  assign wr_acc    = pi_blk_sel & pi_wr_en;
  assign wr_ctrl   = wr_acc && (pi_addr == ADDR_W'(0));
  assign wr_stat   = wr_acc && (pi_addr == ADDR_W'(1));
  // ABORT in the same write cancels GO, so GO only counts without ABORT.
  assign go_req    = wr_ctrl & pi_wr_data[0] & ~pi_wr_data[3];
  assign abort_req = wr_ctrl & pi_wr_data[3];
  assign busy      = (state_q == S_BUSY);

  // Register writes, operation sequencing, watchdog and sticky flag updates
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    int_en_d = int_en_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    r_d      = r_q;
    wd_d     = wd_q;
    go_d     = 1'b0;
    abort_d  = 1'b0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    set_err  = 1'b0;

    if (wr_ctrl) begin
      en_d     = pi_wr_data[1];
      int_en_d = pi_wr_data[2];
      func_d   = pi_wr_data[7:4];
    end

    // Operands are frozen while an operation is running.
    for (int k = 0; k < OP_BYTES; k++) begin
      if (wr_acc && (pi_addr == ADDR_W'(2 + k))) begin
        if (busy) set_err = 1'b1;
        else      a_d[8*k +: 8] = pi_wr_data;
      end
      if (wr_acc && (pi_addr == ADDR_W'(2 + OP_BYTES + k))) begin
        if (busy) set_err = 1'b1;
        else      b_d[8*k +: 8] = pi_wr_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (go_req) begin
          if (pi_wr_data[1] || en_q) begin
            go_d    = 1'b1;
            state_d = S_BUSY;
            wd_d    = WD_W'(TMO_CYC);
          end else begin
            set_err = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (go_req) set_err = 1'b1;
        // Completion outranks both abort sources so a finished result is never lost.
        if (alu_op_done) begin
          q_d      = q_in;
          r_d      = r_in;
          set_done = 1'b1;
          state_d  = S_IDLE;
        end else if (abort_req) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (TMO_CYC != 0) begin
          if (wd_q == WD_W'(1)) begin
            abort_d = 1'b1;
            set_tmo = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q - WD_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flag being set in the same cycle wins over any clear.
    done_d = (done_q & ~(wr_stat & pi_wr_data[1]) & ~interrupt_ack) | set_done;
    tmo_d  = (tmo_q  & ~(wr_stat & pi_wr_data[2]) & ~interrupt_ack) | set_tmo;
    err_d  = (err_q  & ~(wr_stat & pi_wr_data[3]) & ~interrupt_ack) | set_err;
    irq_d  = (done_q | tmo_q | err_q) & int_en_q;
  end

  // State and register storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      int_en_q <= 1'b0;
      func_q   <= 4'h0;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      wd_q     <= '0;
      go_q     <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      int_en_q <= int_en_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      r_q      <= r_d;
      wd_q     <= wd_d;
      go_q     <= go_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  // Read mux; GO and ABORT are write-only and read back as 0
  always_comb begin
    pi_rd_data = 8'h00;
    if (pi_blk_sel && pi_rd_en) begin
      if (pi_addr == ADDR_W'(0)) pi_rd_data = {func_q, 1'b0, int_en_q, en_q, 1'b0};
      if (pi_addr == ADDR_W'(1)) pi_rd_data = {4'h0, err_q, tmo_q, done_q, busy};
      for (int k = 0; k < OP_BYTES; k++) begin
        if (pi_addr == ADDR_W'(2 + k))              pi_rd_data = a_q[8*k +: 8];
        if (pi_addr == ADDR_W'(2 + OP_BYTES + k))   pi_rd_data = b_q[8*k +: 8];
        if (pi_addr == ADDR_W'(2 + 2*OP_BYTES + k)) pi_rd_data = q_q[8*k +: 8];
        if (pi_addr == ADDR_W'(2 + 3*OP_BYTES + k)) pi_rd_data = r_q[8*k +: 8];
      end
    end
  end

  assign interrupt   = irq_q;
  assign alu_go_r    = go_q;
  assign alu_abort_r = abort_q;
  assign alu_en_r    = en_q;
  assign alu_func_r  = func_q;
  assign alu_op_a_r  = a_q;
  assign alu_op_b_r  = b_q;

endmodule
